ip_arp_cache: RTL and testbench
===============================

# ip_arp_cache

Parametrised next-hop ARP resolver for the router output-port-lookup pipeline. It sits directly after the LPM stage. Each LPM result (next-hop IP, output port, LPM hit) is resolved against an internal register-based ARP table to a next-hop MAC, and the result is queued for the process block. Compared with the previous ARP block it adds a configurable address width, per-entry valid bits, lowest-index priority on multiple matches, upstream backpressure, saturating hit/miss counters and a fixed two-stage lookup pipeline with no external CAM.

## Interface

Parameters:
- NUM_QUEUES, 8: width of the one-hot output-port vector.
- LUT_DEPTH, 32: number of ARP entries, 2..256.
- LUT_DEPTH_BITS, log2(LUT_DEPTH): entry index width.
- ADDR_WIDTH, 32: IP key width; 128 selects IPv6.
- FIFO_DEPTH_BITS, 2: result FIFO holds 2**FIFO_DEPTH_BITS entries.
- CNT_WIDTH, 32: width of each statistics counter.

Ports:
- clk  in  1  single clock for the whole block.
- resetn  in  1  asynchronous, active-low reset.
- next_hop_ip  in  ADDR_WIDTH  lookup key.
- lpm_output_port  in  NUM_QUEUES  port, carried through with the lookup.
- lpm_hit  in  1  LPM hit flag, carried through with the lookup.
- lpm_vld  in  1  lookup request.
- lpm_rdy  out  1  block can accept a lookup this cycle.
- next_hop_mac  out  48  head-of-FIFO MAC; 0 on a miss.
- output_port  out  NUM_QUEUES  head-of-FIFO port.
- arp_lookup_hit  out  1  head-of-FIFO ARP hit.
- lpm_lookup_hit  out  1  head-of-FIFO LPM hit.
- arp_mac_vld  out  1  FIFO is non-empty.
- rd_arp_result  in  1  pop the FIFO head.
- arp_rd_addr  in  LUT_DEPTH_BITS  register read index.
- arp_rd_req  in  1  read strobe.
- arp_rd_mac  out  48  MAC of the entry read.
- arp_rd_ip  out  ADDR_WIDTH  IP of the entry read.
- arp_rd_valid  out  1  valid bit of the entry read.
- arp_rd_ack  out  1  one-cycle read-done pulse.
- arp_wr_addr  in  LUT_DEPTH_BITS  register write index.
- arp_wr_req  in  1  write strobe.
- arp_wr_mac  in  48  MAC to write.
- arp_wr_ip  in  ADDR_WIDTH  IP to write.
- arp_wr_valid  in  1  valid bit to write; 0 invalidates the entry.
- arp_wr_ack  out  1  one-cycle write-done pulse.
- counters_clr  in  1  synchronous clear of both counters.
- hit_count  out  CNT_WIDTH  number of ARP hits.
- miss_count  out  CNT_WIDTH  number of ARP misses.

## Operation

Reset, asynchronous on resetn low:
- All valid bits are cleared. Table IP/MAC contents are don't-care.
- The pipeline and FIFO are emptied.
- All outputs read 0, except lpm_rdy, which is 1 once resetn is deasserted.

Lookup pipeline:
- A lookup is accepted when lpm_vld and lpm_rdy are both high.
- S1 registers the key, port and lpm_hit.
- S2 compares the key against every entry whose valid bit is set, in parallel.
  - The lowest matching index wins.
  - On no match: hit=0 and mac=48'h0.
  - S2 then pushes {mac, port, arp_hit, lpm_hit} into the FIFO.
- lpm_hit does not gate the lookup. Lookups with lpm_hit=0 are still resolved and counted.

Backpressure:
- lpm_rdy = (FIFO occupancy + S1 valid + S2 valid) < 2**FIFO_DEPTH_BITS.
- The FIFO therefore never overflows, and the block never drops a lookup.
- lpm_vld while lpm_rdy=0 is ignored. Upstream holds the request.

Result FIFO:
- Fallthrough: the head is valid on the outputs whenever arp_mac_vld=1.
- rd_arp_result while empty is ignored.
- A push and a pop in the same cycle leave the occupancy unchanged.

Table writes:
- On arp_wr_req, entry arp_wr_addr is set to {arp_wr_ip, arp_wr_mac, arp_wr_valid}.

Table reads:
- On arp_rd_req, a snapshot of entry arp_rd_addr is registered onto arp_rd_ip, arp_rd_mac and arp_rd_valid.
- Read-data outputs hold their values until the next read.

Counters:
- Each S2 push increments hit_count (arp hit) or miss_count (arp miss).
- Both counters saturate at all-ones.
- counters_clr takes priority over a same-cycle increment.

## Timing

- Lookup latency: a lookup accepted at edge N is pushed at edge N+2. arp_mac_vld is high after edge N+2 if the FIFO was empty.
- Throughput: one lookup per cycle while lpm_rdy=1.
- Write/lookup ordering: a write sampled at edge W is visible to any lookup whose S2 compare follows W, i.e. lookups accepted at edge W-1 or later. An earlier lookup sees the old contents.
- arp_wr_ack pulses the cycle after arp_wr_req.
- arp_rd_ack pulses the cycle after arp_rd_req.
- A read and a write to the same index in the same cycle: the read returns the old contents.
- Read and write strobes are accepted every cycle. No busy period exists.
- Counters update at the edge of the S2 push and are visible the cycle after.

## Test plan

- Hit: write idx 3 = {10.0.0.1, 00:11:22:33:44:55, valid}, then look up 10.0.0.1 with port 8'h04 and lpm_hit=1.
  - FIFO head after 2 cycles = {00:11:22:33:44:55, 8'h04, 1, 1}.
  - hit_count = 1.
- Miss and invalidate: rewrite idx 3 with valid=0, then look up 10.0.0.1.
  - Head = {0, port, 0, lpm_hit}.
  - miss_count = 1.
- Priority: idx 2 and idx 7 both hold 10.0.0.9, with different MACs.
  - The result carries idx 2's MAC.
- Backpressure: with FIFO_DEPTH_BITS=2 and rd_arp_result=0, drive 6 back-to-back lookups.
  - lpm_rdy drops after 4 acceptances.
  - Popping one entry lets exactly one more lookup be accepted.
  - Results come out in order with no loss.
- Write collision: write idx 5 at edge W while a lookup of the new IP is accepted at W-1 and another at W-2.
  - The W-1 lookup hits.
  - The W-2 lookup misses.
- Reset mid-flight: assert resetn low with 3 results queued.
  - arp_mac_vld goes to 0 immediately.
  - Counters are 0 and all entries are invalid (a readback shows arp_rd_valid=0).
  - lpm_rdy=1 after release.

Source files
------------

// File: rtl/ip_arp_cache_if.sv
// Lookup, result, table-access and statistics signals of the ARP resolver.
// The block is the slave; the LPM stage, the process block and the register host are the master side.
interface ip_arp_cache_if #(
   parameter int NUM_QUEUES     = 8,
   parameter int LUT_DEPTH_BITS = 5,
   parameter int ADDR_WIDTH     = 32,
   parameter int CNT_WIDTH      = 32
);
   logic [ADDR_WIDTH-1:0]     next_hop_ip;
   logic [NUM_QUEUES-1:0]     lpm_output_port;
   logic                      lpm_hit;
   logic                      lpm_vld;
   logic                      lpm_rdy;
   logic [47:0]               next_hop_mac;
   logic [NUM_QUEUES-1:0]     output_port;
   logic                      arp_lookup_hit;
   logic                      lpm_lookup_hit;
   logic                      arp_mac_vld;
   logic                      rd_arp_result;
   logic [LUT_DEPTH_BITS-1:0] arp_rd_addr;
   logic                      arp_rd_req;
   logic [47:0]               arp_rd_mac;
   logic [ADDR_WIDTH-1:0]     arp_rd_ip;
   logic                      arp_rd_valid;
   logic                      arp_rd_ack;
   logic [LUT_DEPTH_BITS-1:0] arp_wr_addr;
   logic                      arp_wr_req;
   logic [47:0]               arp_wr_mac;
   logic [ADDR_WIDTH-1:0]     arp_wr_ip;
   logic                      arp_wr_valid;
   logic                      arp_wr_ack;
   logic                      counters_clr;
   logic [CNT_WIDTH-1:0]      hit_count;
   logic [CNT_WIDTH-1:0]      miss_count;

   modport slave (
      input  next_hop_ip, lpm_output_port, lpm_hit, lpm_vld, rd_arp_result,
             arp_rd_addr, arp_rd_req, arp_wr_addr, arp_wr_req, arp_wr_mac,
             arp_wr_ip, arp_wr_valid, counters_clr,
      output lpm_rdy, next_hop_mac, output_port, arp_lookup_hit, lpm_lookup_hit,
             arp_mac_vld, arp_rd_mac, arp_rd_ip, arp_rd_valid, arp_rd_ack,
             arp_wr_ack, hit_count, miss_count
   );

   modport master (
      output next_hop_ip, lpm_output_port, lpm_hit, lpm_vld, rd_arp_result,
             arp_rd_addr, arp_rd_req, arp_wr_addr, arp_wr_req, arp_wr_mac,
             arp_wr_ip, arp_wr_valid, counters_clr,
      input  lpm_rdy, next_hop_mac, output_port, arp_lookup_hit, lpm_lookup_hit,
             arp_mac_vld, arp_rd_mac, arp_rd_ip, arp_rd_valid, arp_rd_ack,
             arp_wr_ack, hit_count, miss_count
   );
endinterface

// File: rtl/ip_arp_cache.sv
// Next-hop ARP resolver: two-stage register-table lookup feeding a fallthrough result FIFO,
// with credit-style backpressure, table read/write access and saturating hit/miss counters.
module ip_arp_cache #(
   parameter int NUM_QUEUES      = 8,
   parameter int LUT_DEPTH       = 32,
   parameter int LUT_DEPTH_BITS  = $clog2(LUT_DEPTH),
   parameter int ADDR_WIDTH      = 32,
   parameter int FIFO_DEPTH_BITS = 2,
   parameter int CNT_WIDTH       = 32
) (
   input logic           clk,
   input logic           resetn,
   ip_arp_cache_if.slave bus
);
   localparam int FIFO_DEPTH = 2**FIFO_DEPTH_BITS;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] ip;
      logic [47:0]           mac;
   } entry_t;

   typedef struct packed {
      logic [47:0]           mac;
      logic [NUM_QUEUES-1:0] port;
      logic                  arp_hit;
      logic                  lpm_hit;
   } result_t;

   logic [LUT_DEPTH-1:0]       valid_q, valid_d;
   entry_t                     table_q [LUT_DEPTH];
   entry_t                     table_d [LUT_DEPTH];
   logic                       s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
   logic [ADDR_WIDTH-1:0]      s1_ip_q, s1_ip_d, s2_ip_q, s2_ip_d;
   logic [NUM_QUEUES-1:0]      s1_port_q, s1_port_d, s2_port_q, s2_port_d;
   logic                       s1_lpm_hit_q, s1_lpm_hit_d, s2_lpm_hit_q, s2_lpm_hit_d;
   result_t                    fifo_q [FIFO_DEPTH];
   result_t                    fifo_d [FIFO_DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
   logic [CNT_WIDTH-1:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic [47:0]                rd_mac_q, rd_mac_d;
   logic [ADDR_WIDTH-1:0]      rd_ip_q, rd_ip_d;
   logic                       rd_valid_q, rd_valid_d, rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;

   logic [FIFO_DEPTH_BITS+1:0] occupancy;
   logic                       lpm_rdy, accept, push, pop, nonempty, s2_hit;
   logic [47:0]                s2_mac;
   result_t                    head;

   // Every lookup in flight already owns a FIFO slot, so the FIFO can never overflow.
   assign occupancy = {1'b0, count_q}
                    + {{(FIFO_DEPTH_BITS+1){1'b0}}, s1_vld_q}
                    + {{(FIFO_DEPTH_BITS+1){1'b0}}, s2_vld_q};
   assign lpm_rdy  = resetn && (int'(occupancy) < FIFO_DEPTH);
   assign accept   = bus.lpm_vld && lpm_rdy;
   assign push     = s2_vld_q;
   assign nonempty = (count_q != '0);
   assign pop      = bus.rd_arp_result && nonempty;

   // Descending scan so the lowest matching index is the last to assign.
   always_comb begin
      s2_hit = 1'b0;
      s2_mac = '0;
      for (int i = LUT_DEPTH-1; i >= 0; i--) begin
         if (valid_q[i] && (table_q[i].ip == s2_ip_q)) begin
            s2_hit = 1'b1;
            s2_mac = table_q[i].mac;
         end
      end
   end

   always_comb begin
      s1_vld_d     = accept;
      s1_ip_d      = accept ? bus.next_hop_ip : s1_ip_q;
      s1_port_d    = accept ? bus.lpm_output_port : s1_port_q;
      s1_lpm_hit_d = accept ? bus.lpm_hit : s1_lpm_hit_q;
      s2_vld_d     = s1_vld_q;
      s2_ip_d      = s1_ip_q;
      s2_port_d    = s1_port_q;
      s2_lpm_hit_d = s1_lpm_hit_q;

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{mac: s2_mac, port: s2_port_q, arp_hit: s2_hit, lpm_hit: s2_lpm_hit_q};
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (bus.counters_clr) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end else if (push) begin
         if (s2_hit && (hit_cnt_q != '1))        hit_cnt_d  = hit_cnt_q + 1'b1;
         else if (!s2_hit && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
      end

      valid_d  = valid_q;
      table_d  = table_q;
      wr_ack_d = bus.arp_wr_req;
      if (bus.arp_wr_req && (int'(bus.arp_wr_addr) < LUT_DEPTH)) begin
         valid_d[bus.arp_wr_addr] = bus.arp_wr_valid;
         table_d[bus.arp_wr_addr] = '{ip: bus.arp_wr_ip, mac: bus.arp_wr_mac};
      end

      // Reads sample the pre-write table, so a same-index write is not seen.
      rd_mac_d   = rd_mac_q;
      rd_ip_d    = rd_ip_q;
      rd_valid_d = rd_valid_q;
      rd_ack_d   = bus.arp_rd_req;
      if (bus.arp_rd_req) begin
         if (int'(bus.arp_rd_addr) < LUT_DEPTH) begin
            rd_mac_d   = table_q[bus.arp_rd_addr].mac;
            rd_ip_d    = table_q[bus.arp_rd_addr].ip;
            rd_valid_d = valid_q[bus.arp_rd_addr];
         end else begin
            rd_mac_d   = '0;
            rd_ip_d    = '0;
            rd_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q      <= '0;
         s1_vld_q     <= 1'b0;
         s1_ip_q      <= '0;
         s1_port_q    <= '0;
         s1_lpm_hit_q <= 1'b0;
         s2_vld_q     <= 1'b0;
         s2_ip_q      <= '0;
         s2_port_q    <= '0;
         s2_lpm_hit_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         rd_mac_q     <= '0;
         rd_ip_q      <= '0;
         rd_valid_q   <= 1'b0;
         rd_ack_q     <= 1'b0;
         wr_ack_q     <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         s1_vld_q     <= s1_vld_d;
         s1_ip_q      <= s1_ip_d;
         s1_port_q    <= s1_port_d;
         s1_lpm_hit_q <= s1_lpm_hit_d;
         s2_vld_q     <= s2_vld_d;
         s2_ip_q      <= s2_ip_d;
         s2_port_q    <= s2_port_d;
         s2_lpm_hit_q <= s2_lpm_hit_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         rd_mac_q     <= rd_mac_d;
         rd_ip_q      <= rd_ip_d;
         rd_valid_q   <= rd_valid_d;
         rd_ack_q     <= rd_ack_d;
         wr_ack_q     <= wr_ack_d;
      end
   end

   // Table and FIFO payloads are qualified by valid bits / occupancy, so they carry no reset.
   always_ff @(posedge clk) begin
      table_q <= table_d;
      fifo_q  <= fifo_d;
   end

   assign head               = fifo_q[rd_ptr_q];
   assign bus.lpm_rdy        = lpm_rdy;
   assign bus.arp_mac_vld    = nonempty;
   assign bus.next_hop_mac   = nonempty ? head.mac : '0;
   assign bus.output_port    = nonempty ? head.port : '0;
   assign bus.arp_lookup_hit = nonempty && head.arp_hit;
   assign bus.lpm_lookup_hit = nonempty && head.lpm_hit;
   assign bus.arp_rd_mac     = rd_mac_q;
   assign bus.arp_rd_ip      = rd_ip_q;
   assign bus.arp_rd_valid   = rd_valid_q;
   assign bus.arp_rd_ack     = rd_ack_q;
   assign bus.arp_wr_ack     = wr_ack_q;
   assign bus.hit_count      = hit_cnt_q;
   assign bus.miss_count     = miss_cnt_q;
endmodule

// File: tb/tb_ip_arp_cache.sv
// Bench for ip_arp_cache: directed scenarios with literal expectations, then random traffic,
// all checked each cycle against a behavioural table/queue model of the resolver.
module tb_ip_arp_cache;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   ip_arp_cache_if #(.NUM_QUEUES(8), .LUT_DEPTH_BITS(5), .ADDR_WIDTH(32), .CNT_WIDTH(32)) bus ();

   ip_arp_cache #(.NUM_QUEUES(8), .LUT_DEPTH(32), .LUT_DEPTH_BITS(5), .ADDR_WIDTH(32),
                  .FIFO_DEPTH_BITS(2), .CNT_WIDTH(32))
      dut (.clk(clk), .resetn(resetn), .bus(bus));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic [31:0] ip; logic [7:0] port; logic lpm; int due; } look_t;
   typedef struct { logic [47:0] mac; logic [7:0] port; logic ah; logic lh; } res_t;

   look_t       pend[$];
   res_t        mfifo[$];
   logic [31:0] m_ip  [32];
   logic [47:0] m_mac [32];
   bit          m_val [32];
   logic [31:0] m_hit = 0, m_miss = 0;
   logic [47:0] m_rd_mac = 0;
   logic [31:0] m_rd_ip = 0;
   logic        m_rd_val = 0, m_rd_ack = 0, m_wr_ack = 0;
   int          cyc = 0;
   bit          m_acc, m_pop;
   res_t        m_r;

   function automatic res_t resolve(input look_t l);
      res_t r;
      r.mac = 48'h0; r.ah = 1'b0; r.port = l.port; r.lh = l.lpm;
      for (int i = 0; i < 32; i++) begin
         if (m_val[i] && m_ip[i] == l.ip) begin
            r.mac = m_mac[i]; r.ah = 1'b1;
            break;
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend.delete(); mfifo.delete();
         m_hit = 0; m_miss = 0; m_rd_mac = 0; m_rd_ip = 0; m_rd_val = 0;
         m_rd_ack = 0; m_wr_ack = 0; cyc = 0;
         for (int i = 0; i < 32; i++) m_val[i] = 0;
      end else begin
         m_acc = bus.lpm_vld && (pend.size() + mfifo.size() < 4);
         m_pop = bus.rd_arp_result && (mfifo.size() > 0);
         cyc++;
         m_r.ah = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            m_r = resolve(pend[0]);
            void'(pend.pop_front());
            mfifo.push_back(m_r);
            if (m_r.ah) begin if (m_hit != '1) m_hit++; end
            else begin if (m_miss != '1) m_miss++; end
         end
         if (m_pop) void'(mfifo.pop_front());
         if (bus.counters_clr) begin m_hit = 0; m_miss = 0; end
         m_rd_ack = bus.arp_rd_req;
         m_wr_ack = bus.arp_wr_req;
         if (bus.arp_rd_req) begin
            m_rd_mac = m_val[bus.arp_rd_addr] || 1'b1 ? m_mac[bus.arp_rd_addr] : 48'h0;
            m_rd_ip  = m_ip[bus.arp_rd_addr];
            m_rd_val = m_val[bus.arp_rd_addr];
         end
         if (bus.arp_wr_req) begin
            m_ip[bus.arp_wr_addr]  = bus.arp_wr_ip;
            m_mac[bus.arp_wr_addr] = bus.arp_wr_mac;
            m_val[bus.arp_wr_addr] = bus.arp_wr_valid;
         end
         if (m_acc) pend.push_back('{bus.next_hop_ip, bus.lpm_output_port, bus.lpm_hit, cyc + 2});
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      wait (resetn === 1'b1);
      forever begin
         @(posedge clk); #1;
         chk("lpm_rdy", bus.lpm_rdy, resetn && (pend.size() + mfifo.size() < 4));
         chk("arp_mac_vld", bus.arp_mac_vld, mfifo.size() > 0);
         if (mfifo.size() > 0) begin
            chk("head_mac", bus.next_hop_mac, mfifo[0].mac);
            chk("head_port", bus.output_port, mfifo[0].port);
            chk("head_arp_hit", bus.arp_lookup_hit, mfifo[0].ah);
            chk("head_lpm_hit", bus.lpm_lookup_hit, mfifo[0].lh);
         end
         chk("hit_count", bus.hit_count, m_hit);
         chk("miss_count", bus.miss_count, m_miss);
         chk("rd_ack", bus.arp_rd_ack, m_rd_ack);
         chk("wr_ack", bus.arp_wr_ack, m_wr_ack);
         chk("rd_valid", bus.arp_rd_valid, m_rd_val);
         if (m_rd_val) begin
            chk("rd_ip", bus.arp_rd_ip, m_rd_ip);
            chk("rd_mac", bus.arp_rd_mac, m_rd_mac);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      bus.lpm_vld = 0; bus.rd_arp_result = 0; bus.arp_rd_req = 0;
      bus.arp_wr_req = 0; bus.counters_clr = 0;
   endtask

   task automatic wr_entry(input int idx, input logic [31:0] ip, input logic [47:0] mac, input logic v);
      @(negedge clk);
      bus.arp_wr_addr = 5'(idx); bus.arp_wr_ip = ip; bus.arp_wr_mac = mac;
      bus.arp_wr_valid = v; bus.arp_wr_req = 1;
      @(negedge clk);
      bus.arp_wr_req = 0;
   endtask

   task automatic rd_entry(input int idx);
      @(negedge clk);
      bus.arp_rd_addr = 5'(idx); bus.arp_rd_req = 1;
      @(negedge clk);
      bus.arp_rd_req = 0;
   endtask

   task automatic lookup(input logic [31:0] ip, input logic [7:0] port, input logic lh);
      @(negedge clk);
      bus.next_hop_ip = ip; bus.lpm_output_port = port; bus.lpm_hit = lh; bus.lpm_vld = 1;
      for (int g = 0; g < 200 && !bus.lpm_rdy; g++) @(negedge clk);
      chk("lookup_accept_timeout", bus.lpm_rdy, 1'b1);
      @(negedge clk);
      bus.lpm_vld = 0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      bus.rd_arp_result = 1;
      @(negedge clk);
      bus.rd_arp_result = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int acc, k;
      logic rdy_now;
      resetn = 0;
      bus.next_hop_ip = 0; bus.lpm_output_port = 0; bus.lpm_hit = 0;
      bus.arp_rd_addr = 0; bus.arp_wr_addr = 0; bus.arp_wr_mac = 0;
      bus.arp_wr_ip = 0; bus.arp_wr_valid = 0;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1;
      #1;
      chk("reset_rdy", bus.lpm_rdy, 1);
      chk("reset_vld", bus.arp_mac_vld, 0);
      chk("reset_hits", bus.hit_count, 0);
      chk("reset_miss", bus.miss_count, 0);

      // Hit, with latency check
      wr_entry(3, 32'h0A000001, 48'h001122334455, 1);
      lookup(32'h0A000001, 8'h04, 1);
      @(posedge clk); #2;
      chk("hit_lat_n1_vld", bus.arp_mac_vld, 0);
      @(posedge clk); #2;
      chk("hit_vld", bus.arp_mac_vld, 1);
      chk("hit_mac", bus.next_hop_mac, 48'h001122334455);
      chk("hit_port", bus.output_port, 8'h04);
      chk("hit_arp", bus.arp_lookup_hit, 1);
      chk("hit_lpm", bus.lpm_lookup_hit, 1);
      @(posedge clk); #2;
      chk("hit_count_1", bus.hit_count, 1);
      pop_one();

      // Miss after invalidate, lpm_hit=0 still resolved
      wr_entry(3, 32'h0A000001, 48'h001122334455, 0);
      lookup(32'h0A000001, 8'h10, 0);
      repeat (2) @(posedge clk); #2;
      chk("miss_mac", bus.next_hop_mac, 0);
      chk("miss_port", bus.output_port, 8'h10);
      chk("miss_arp", bus.arp_lookup_hit, 0);
      chk("miss_lpm", bus.lpm_lookup_hit, 0);
      @(posedge clk); #2;
      chk("miss_count_1", bus.miss_count, 1);
      pop_one();

      // Lowest index wins
      wr_entry(7, 32'h0A000009, 48'hBBBB00000007, 1);
      wr_entry(2, 32'h0A000009, 48'hAAAA00000002, 1);
      lookup(32'h0A000009, 8'h01, 1);
      repeat (2) @(posedge clk); #2;
      chk("prio_mac", bus.next_hop_mac, 48'hAAAA00000002);
      pop_one();

      // Backpressure: 6 back-to-back requests into a 4-deep FIFO
      acc = 0; k = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         bus.lpm_vld = (k < 6);
         bus.next_hop_ip = 32'h0A000100 + 32'(k);
         bus.lpm_output_port = 8'(k + 1);
         bus.lpm_hit = 1;
         bus.rd_arp_result = (c == 8) || (c >= 13);
         rdy_now = bus.lpm_rdy;
         @(posedge clk);
         if (bus.lpm_vld && rdy_now) begin acc++; k++; end
         if (c == 7) begin
            chk("bp_acc_4", 32'(acc), 4);
            chk("bp_rdy_low", rdy_now, 0);
         end
         if (c == 12) chk("bp_acc_5", 32'(acc), 5);
      end
      @(negedge clk);
      idle();
      chk("bp_acc_6", 32'(acc), 6);
      chk("bp_drained", bus.arp_mac_vld, 0);

      // Write/lookup ordering at the write edge W
      @(negedge clk);
      bus.next_hop_ip = 32'h0A000055; bus.lpm_output_port = 8'h01; bus.lpm_vld = 1;
      @(negedge clk);
      bus.lpm_output_port = 8'h02;
      @(negedge clk);
      bus.lpm_vld = 0;
      bus.arp_wr_addr = 5; bus.arp_wr_ip = 32'h0A000055; bus.arp_wr_mac = 48'hC0FFEE000005;
      bus.arp_wr_valid = 1; bus.arp_wr_req = 1;
      @(negedge clk);
      bus.arp_wr_req = 0;
      repeat (2) @(posedge clk); #2;
      chk("coll_wm2_port", bus.output_port, 8'h01);
      chk("coll_wm2_miss", bus.arp_lookup_hit, 0);
      pop_one();
      #1;
      chk("coll_wm1_port", bus.output_port, 8'h02);
      chk("coll_wm1_hit", bus.arp_lookup_hit, 1);
      chk("coll_wm1_mac", bus.next_hop_mac, 48'hC0FFEE000005);
      pop_one();

      // Reset with results queued
      rd_entry(5);
      chk("pre_rst_rd_valid", bus.arp_rd_valid, 1);
      chk("pre_rst_rd_ip", bus.arp_rd_ip, 32'h0A000055);
      chk("pre_rst_rd_ack", bus.arp_rd_ack, 1);
      @(negedge clk);
      bus.next_hop_ip = 32'h0A000055; bus.lpm_vld = 1;
      repeat (3) @(negedge clk);
      bus.lpm_vld = 0;
      repeat (3) @(posedge clk); #3;
      chk("pre_rst_vld", bus.arp_mac_vld, 1);
      resetn = 0;
      #1;
      chk("rst_vld", bus.arp_mac_vld, 0);
      chk("rst_hits", bus.hit_count, 0);
      chk("rst_miss", bus.miss_count, 0);
      @(negedge clk) resetn = 1;
      #1;
      chk("rst_rdy", bus.lpm_rdy, 1);
      rd_entry(5);
      chk("rst_rd5_valid", bus.arp_rd_valid, 0);
      chk("rst_rd5_ack", bus.arp_rd_ack, 1);
      rd_entry(2);
      chk("rst_rd2_valid", bus.arp_rd_valid, 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         bus.lpm_vld         = ($urandom_range(0, 99) < 60);
         bus.next_hop_ip     = 32'h0A000100 + 32'($urandom_range(0, 9));
         bus.lpm_output_port = 8'($urandom);
         bus.lpm_hit         = 1'($urandom);
         bus.rd_arp_result   = ($urandom_range(0, 99) < 55);
         bus.arp_wr_req      = ($urandom_range(0, 99) < 20);
         bus.arp_wr_addr     = 5'($urandom_range(0, 15));
         bus.arp_wr_ip       = 32'h0A000100 + 32'($urandom_range(0, 9));
         bus.arp_wr_mac      = {16'($urandom), 32'($urandom)};
         bus.arp_wr_valid    = ($urandom_range(0, 99) < 80);
         bus.arp_rd_req      = ($urandom_range(0, 99) < 25);
         bus.arp_rd_addr     = 5'($urandom_range(0, 15));
         bus.counters_clr    = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      idle();
      bus.rd_arp_result = 1;
      repeat (12) @(negedge clk);
      bus.rd_arp_result = 0;
      #1;
      chk("final_drained", bus.arp_mac_vld, 0);
      @(posedge clk); #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
